// File: rtl/stdp_learn_core.sv
// Pair-based STDP learning engine: NUM_PRE presynaptic channels onto one postsynaptic neuron.
// Latency: weights update at the edge the triggering spike is sampled; update flags/dt visible the following cycle.
// Backpressure: none; spikes are sampled every edge and the engine never stalls.
module stdp_learn_core #(
    parameter int NUM_PRE   = 5,
    parameter int TIMER_W   = 8,
    parameter int WEIGHT_W  = 8,
    parameter int WINDOW    = 16,
    parameter int A_PLUS    = 8,
    parameter int A_MINUS   = 6,
    parameter int TAU_SHIFT = 2,
    parameter int W_INIT    = 128,
    parameter int SEL_W     = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          learn_en,
    input  logic [NUM_PRE-1:0]            pre_spike,
    input  logic                          post_spike,
    input  logic [SEL_W-1:0]              weight_sel,
    output logic [NUM_PRE*WEIGHT_W-1:0]   weights_flat,
    output logic [WEIGHT_W-1:0]           weight_out,
    output logic                          update_valid,
    output logic [NUM_PRE-1:0]            update_mask,
    output logic signed [TIMER_W:0]       dt_out
);

    localparam logic [TIMER_W-1:0]  T_SAT  = '1;
    localparam logic [TIMER_W-1:0]  T_WIN  = TIMER_W'(WINDOW);
    localparam logic [WEIGHT_W-1:0] W_MAX  = '1;
    localparam logic [WEIGHT_W-1:0] W_RST  = WEIGHT_W'(W_INIT);
    localparam logic [WEIGHT_W-1:0] A_P    = WEIGHT_W'(A_PLUS);
    localparam logic [WEIGHT_W-1:0] A_M    = WEIGHT_W'(A_MINUS);
    localparam logic [TIMER_W:0]    ONE_DT = (TIMER_W+1)'(1);

    // Spike-age timers: all-ones means "no spike seen recently"
    logic [TIMER_W-1:0]        r_t_pre [NUM_PRE];
    logic [TIMER_W-1:0]        r_t_post;
    logic [WEIGHT_W-1:0]       r_w     [NUM_PRE];
    logic signed [TIMER_W:0]   r_dt    [NUM_PRE];
    logic [NUM_PRE-1:0]        r_mask;
    logic                      r_valid;

    logic [NUM_PRE-1:0]        w_ltp;
    logic [NUM_PRE-1:0]        w_ltd;
    logic [NUM_PRE-1:0]        w_upd;
    logic [WEIGHT_W-1:0]       w_d     [NUM_PRE];
    logic [WEIGHT_W:0]         w_sum   [NUM_PRE];
    logic [WEIGHT_W-1:0]       w_w_nxt [NUM_PRE];
    logic [TIMER_W:0]          w_dt_nxt[NUM_PRE];

    // Learning rule: evaluated on this edge's spikes against the pre-edge timer values
    always_comb begin
        for (int i = 0; i < NUM_PRE; i++) begin
            w_ltp[i]    = post_spike & ~pre_spike[i] & (r_t_pre[i] < T_WIN);
            w_ltd[i]    = pre_spike[i] & ~post_spike & (r_t_post < T_WIN);
            w_d[i]      = '0;
            w_sum[i]    = '0;
            w_w_nxt[i]  = r_w[i];
            w_dt_nxt[i] = r_dt[i];
            if (w_ltp[i]) begin
                // Oversized shifts naturally collapse the delta to zero
                w_d[i]      = A_P >> (r_t_pre[i] >> TAU_SHIFT);
                w_sum[i]    = {1'b0, r_w[i]} + {1'b0, w_d[i]};
                w_w_nxt[i]  = w_sum[i][WEIGHT_W] ? W_MAX : w_sum[i][WEIGHT_W-1:0];
                w_dt_nxt[i] = {1'b0, r_t_pre[i]} + ONE_DT;
            end else if (w_ltd[i]) begin
                w_d[i]      = A_M >> (r_t_post >> TAU_SHIFT);
                w_sum[i]    = {1'b0, r_w[i]} - {1'b0, w_d[i]};
                // A borrow into the top bit means the weight went below zero
                w_w_nxt[i]  = w_sum[i][WEIGHT_W] ? '0 : w_sum[i][WEIGHT_W-1:0];
                w_dt_nxt[i] = '0 - ({1'b0, r_t_post} + ONE_DT);
            end
            w_upd[i] = learn_en & (w_d[i] != '0);
        end
    end

    // Timers run regardless of learn_en and saturate instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRE; i++) r_t_pre[i] <= T_SAT;
            r_t_post <= T_SAT;
        end else begin
            for (int i = 0; i < NUM_PRE; i++) begin
                if (pre_spike[i])           r_t_pre[i] <= '0;
                else if (r_t_pre[i] != T_SAT) r_t_pre[i] <= r_t_pre[i] + 1'b1;
            end
            if (post_spike)             r_t_post <= '0;
            else if (r_t_post != T_SAT) r_t_post <= r_t_post + 1'b1;
        end
    end

    // Weight and per-channel dt storage; only updated channels change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRE; i++) begin
                r_w[i]  <= W_RST;
                r_dt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PRE; i++) begin
                if (w_upd[i]) begin
                    r_w[i]  <= w_w_nxt[i];
                    r_dt[i] <= w_dt_nxt[i];
                end
            end
        end
    end

    // Update flags describe the most recent edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_mask  <= w_upd;
            r_valid <= |w_upd;
        end
    end

    // Readout: flat weight bus plus a select mux that returns zero for unused select codes
    always_comb begin
        weight_out = '0;
        dt_out     = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            weights_flat[i*WEIGHT_W +: WEIGHT_W] = r_w[i];
            if (weight_sel == SEL_W'(i)) begin
                weight_out = r_w[i];
                dt_out     = r_dt[i];
            end
        end
    end

    assign update_mask  = r_mask;
    assign update_valid = r_valid;

endmodule

// File: tb/tb_stdp_learn_core.sv
module tb_stdp_learn_core;

    localparam int NP = 5;
    localparam int TW = 8;
    localparam int WW = 8;
    localparam int SW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 learn_en;
    logic [NP-1:0]        pre_spike;
    logic                 post_spike;
    logic [SW-1:0]        weight_sel;
    logic [NP*WW-1:0]     weights_flat;
    logic [WW-1:0]        weight_out;
    logic                 update_valid;
    logic [NP-1:0]        update_mask;
    logic signed [TW:0]   dt_out;

    int n_checks = 0;
    int n_err    = 0;

    stdp_learn_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .weight_sel   (weight_sel),
        .weights_flat (weights_flat),
        .weight_out   (weight_out),
        .update_valid (update_valid),
        .update_mask  (update_mask),
        .dt_out       (dt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present spikes for one rising edge, then sample 1 time unit after it
    task automatic edge_in(input logic [NP-1:0] pre, input logic post);
        pre_spike  = pre;
        post_spike = post;
        @(posedge clk);
        #1;
        pre_spike  = '0;
        post_spike = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) edge_in('0, 1'b0);
    endtask

    function automatic logic [WW-1:0] wt(input int ch);
        return weights_flat[ch*WW +: WW];
    endfunction

    initial begin
        rst_n      = 1'b0;
        learn_en   = 1'b1;
        pre_spike  = '0;
        post_spike = 1'b0;
        weight_sel = '0;
        #12;
        chk("rst_flat",  weights_flat, 40'h80_80_80_80_80);
        chk("rst_valid", update_valid, 1'b0);
        chk("rst_mask",  update_mask,  5'b00000);
        chk("rst_dt",    dt_out,       9'sd0);
        chk("rst_wout",  weight_out,   8'd128);
        @(negedge clk);
        rst_n = 1'b1;

        // Post spike right after reset: timers saturated, nothing learns
        edge_in('0, 1'b1);
        chk("post_first_valid", update_valid, 1'b0);
        chk("post_first_flat",  weights_flat, 40'h80_80_80_80_80);

        // LTP: pre0 at k, post at k+3 -> +8, dt=+3
        idle(20);
        edge_in(5'b00001, 1'b0);
        idle(2);
        edge_in('0, 1'b1);
        chk("ltp_w0",    wt(0),        8'd136);
        chk("ltp_mask",  update_mask,  5'b00001);
        chk("ltp_valid", update_valid, 1'b1);
        chk("ltp_dt",    dt_out,       9'sd3);
        chk("ltp_wout",  weight_out,   8'd136);
        idle(1);
        chk("ltp_valid_drop", update_valid, 1'b0);
        chk("ltp_mask_drop",  update_mask,  5'b00000);
        chk("ltp_dt_hold",    dt_out,       9'sd3);

        // LTD: post at k, pre2 at k+9 -> t_post=8, d=6>>2=1, dt=-9
        idle(20);
        edge_in('0, 1'b1);
        idle(8);
        edge_in(5'b00100, 1'b0);
        weight_sel = 3'd2;
        #1;
        chk("ltd_w2",    wt(2),        8'd127);
        chk("ltd_mask",  update_mask,  5'b00100);
        chk("ltd_valid", update_valid, 1'b1);
        chk("ltd_dt",    dt_out,       -9'sd9);
        chk("ltd_wout",  weight_out,   8'd127);
        weight_sel = 3'd0;
        #1;
        chk("dt_ch0_held", dt_out, 9'sd3);
        weight_sel = 3'd5;
        #1;
        chk("sel_oor_wout", weight_out, 8'd0);
        chk("sel_oor_dt",   dt_out,     9'sd0);

        // Outside the window: pre1 at k, post at k+20 (age 19)
        idle(20);
        edge_in(5'b00010, 1'b0);
        idle(19);
        edge_in('0, 1'b1);
        chk("win_valid", update_valid, 1'b0);
        chk("win_flat",  weights_flat, 40'h80_80_7F_80_88);

        // learn_en=0 freezes weights even for a valid pairing
        idle(20);
        learn_en = 1'b0;
        edge_in(5'b00001, 1'b0);
        idle(2);
        edge_in('0, 1'b1);
        chk("frz_mask",  update_mask,  5'b00000);
        chk("frz_valid", update_valid, 1'b0);
        chk("frz_w0",    wt(0),        8'd136);
        learn_en = 1'b1;

        // Upper clamp: dt=+1 pairings on channel 4, gaps keep LTD out of the way
        idle(20);
        for (int n = 0; n < 15; n++) begin
            edge_in(5'b10000, 1'b0);
            edge_in('0, 1'b1);
            idle(17);
        end
        chk("sat_w4_248", wt(4), 8'd248);
        weight_sel = 3'd4;
        edge_in(5'b10000, 1'b0);
        edge_in('0, 1'b1);
        chk("sat_w4_255",  wt(4),        8'd255);
        chk("sat_mask",    update_mask,  5'b10000);
        chk("sat_dt",      dt_out,       9'sd1);
        idle(17);
        edge_in(5'b10000, 1'b0);
        edge_in('0, 1'b1);
        chk("sat_w4_hold", wt(4),        8'd255);
        chk("sat_mask2",   update_mask,  5'b10000);
        chk("sat_valid2",  update_valid, 1'b1);
        idle(17);

        // Lower clamp: dt=-1 pairings on channel 1, 128 - 21*6 = 2, then clamps to 0
        weight_sel = 3'd1;
        for (int n = 0; n < 21; n++) begin
            edge_in('0, 1'b1);
            edge_in(5'b00010, 1'b0);
            idle(17);
        end
        chk("neg_w1_2", wt(1), 8'd2);
        edge_in('0, 1'b1);
        edge_in(5'b00010, 1'b0);
        chk("neg_w1_0",  wt(1),       8'd0);
        chk("neg_mask",  update_mask, 5'b00010);
        chk("neg_dt",    dt_out,      -9'sd1);
        idle(17);
        edge_in('0, 1'b1);
        edge_in(5'b00010, 1'b0);
        chk("neg_w1_hold", wt(1),       8'd0);
        chk("neg_mask2",   update_mask, 5'b00010);

        // Coincident pre3 & post: no change; post on the next edge then gives +8
        idle(20);
        weight_sel = 3'd3;
        edge_in(5'b01000, 1'b1);
        chk("coin_valid", update_valid, 1'b0);
        chk("coin_w3",    wt(3),        8'd128);
        edge_in('0, 1'b1);
        chk("coin_next_w3",   wt(3),        8'd136);
        chk("coin_next_mask", update_mask,  5'b01000);
        chk("coin_next_dt",   dt_out,       9'sd1);
        chk("all_flat",       weights_flat, 40'hFF_88_7F_00_88);

        // Asynchronous reset mid-sequence wipes everything immediately
        idle(20);
        edge_in(5'b00001, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_flat",  weights_flat, 40'h80_80_80_80_80);
        chk("mrst_valid", update_valid, 1'b0);
        chk("mrst_mask",  update_mask,  5'b00000);
        chk("mrst_dt",    dt_out,       9'sd0);
        #2;
        rst_n = 1'b1;
        edge_in('0, 1'b1);
        chk("mrst_no_pending", update_valid, 1'b0);
        chk("mrst_w0",         wt(0),        8'd128);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
